// File: rtl/pa_riscv.sv
// Shared RV32I constants for the multicycle core: opcodes, ALU operation
// encodings, datapath mux select encodings and the controller state type.
package pa_riscv;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LW      = 7'b0000011;
  localparam logic [6:0] OP_SW      = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE  = 7'b0010011;
  localparam logic [6:0] OP_B_TYPE  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;

  // ALU operations, encoded as {funct7bit5, funct3}
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Main controller states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } mc_state_e;

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// ALU operation decoder. Outside the execute states the ALU is only used
// for address/PC arithmetic, so it defaults to ADD.
module alu_op_decoder
  import pa_riscv::*;
(
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_execute,
  output logic [3:0] o_aluLogicOperation
);

  // Select the instruction's own ALU op only while executing it
  always_comb begin
    o_aluLogicOperation = ALU_ADD;
    if (i_execute) begin
      case (i_operand)
        OP_R_TYPE: o_aluLogicOperation = {i_funct7bit5, i_funct3};
        OP_I_TYPE: o_aluLogicOperation = {1'b0, i_funct3};
        OP_B_TYPE: o_aluLogicOperation = ALU_SUB;
        default:   o_aluLogicOperation = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle RV32I core. Sequences fetch, decode, execute,
// memory and writeback over a shared memory with a ready handshake.
// Optional feature macro: MULTICYCLE_PERF_CNT_EN adds cycle and
// retired-instruction counters (o_cycleCount, o_instRetCount).
module multicycle_controller
  import pa_riscv::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [6:0]         i_operand,
  input  logic [2:0]         i_funct3,
  input  logic               i_funct7bit5,
  input  logic               i_zeroFlag,
  input  logic               i_memReady,
  output logic               o_memReq,
  output logic               o_memWriteEn,
  output logic               o_adrSrc,
  output logic               o_irWriteEn,
  output logic               o_pcWriteEn,
  output logic               o_regWriteEn,
  output logic [1:0]         o_aluSrcA,
  output logic [1:0]         o_aluSrcB,
  output logic [1:0]         o_resultSrc,
  output logic [3:0]         o_aluLogicOperation,
`ifdef MULTICYCLE_PERF_CNT_EN
  output logic [COUNT_W-1:0] o_cycleCount,
  output logic [COUNT_W-1:0] o_instRetCount,
`endif
  output logic               o_illegal
);

  if (COUNT_W < 1) begin : g_bad_count_w
    $error("COUNT_W must be at least 1");
  end

  mc_state_e state_q, state_d;
  logic      alu_execute;

  // State register; reset abandons any in-flight access
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state output decode
  always_comb begin
    state_d      = state_q;
    o_memReq     = 1'b0;
    o_memWriteEn = 1'b0;
    o_adrSrc     = 1'b0;
    o_irWriteEn  = 1'b0;
    o_pcWriteEn  = 1'b0;
    o_regWriteEn = 1'b0;
    o_aluSrcA    = SRCA_PC;
    o_aluSrcB    = SRCB_RS2;
    o_resultSrc  = RES_ALUOUT;
    o_illegal    = 1'b0;
    alu_execute  = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_memReq    = 1'b1;
        o_aluSrcA   = SRCA_PC;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSrc = RES_ALU;
        o_irWriteEn = i_memReady;
        o_pcWriteEn = i_memReady;
        if (i_memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        o_aluSrcA = SRCA_OLDPC;
        o_aluSrcB = SRCB_IMM;
        case (i_operand)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R_TYPE:    state_d = S_EXECUTER;
          OP_I_TYPE:    state_d = S_EXECUTEI;
          OP_B_TYPE:    state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            o_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA = SRCA_RS1;
        o_aluSrcB = SRCB_IMM;
        state_d   = (i_operand == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_memReq    = 1'b1;
        o_adrSrc    = 1'b1;
        o_resultSrc = RES_ALUOUT;
        if (i_memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc  = RES_DATA;
        o_regWriteEn = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        o_memReq     = 1'b1;
        o_memWriteEn = 1'b1;
        o_adrSrc     = 1'b1;
        o_resultSrc  = RES_ALUOUT;
        if (i_memReady) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        o_aluSrcA   = SRCA_RS1;
        o_aluSrcB   = SRCB_RS2;
        alu_execute = 1'b1;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_aluSrcA   = SRCA_RS1;
        o_aluSrcB   = SRCB_IMM;
        alu_execute = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        o_resultSrc  = RES_ALUOUT;
        o_regWriteEn = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ: begin
        o_aluSrcA   = SRCA_RS1;
        o_aluSrcB   = SRCB_RS2;
        o_resultSrc = RES_ALUOUT;
        o_pcWriteEn = i_zeroFlag;
        alu_execute = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // Branch target was computed into aluOut during DECODE; here the
        // ALU forms the link address oldPC+4 for the ALUWB writeback.
        o_aluSrcA   = SRCA_OLDPC;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSrc = RES_ALUOUT;
        o_pcWriteEn = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .i_operand           (i_operand),
    .i_funct3            (i_funct3),
    .i_funct7bit5        (i_funct7bit5),
    .i_execute           (alu_execute),
    .o_aluLogicOperation (o_aluLogicOperation)
  );

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [COUNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [COUNT_W-1:0] inst_ret_count_q, inst_ret_count_d;
  logic               retire;

  // Retirement is any return to FETCH that completed an instruction
  always_comb begin
    retire = (state_d == S_FETCH) &&
             ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
              (state_q == S_ALUWB) || (state_q == S_BEQ));
    cycle_count_d    = cycle_count_q + 1'b1;
    inst_ret_count_d = inst_ret_count_q + {{(COUNT_W-1){1'b0}}, retire};
  end

  // Free-running wrapping performance counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycle_count_q    <= '0;
      inst_ret_count_q <= '0;
    end else begin
      cycle_count_q    <= cycle_count_d;
      inst_ret_count_q <= inst_ret_count_d;
    end
  end

  assign o_cycleCount   = cycle_count_q;
  assign o_instRetCount = inst_ret_count_q;
`endif

endmodule
